// File: rtl/instr_encoder.sv
// LEGv8 R/D-format instruction word packer that streams encoded words into
// instruction memory at sequential byte addresses through a one-entry output register.
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module instr_encoder #(
    parameter int unsigned INSTR_LEN = `INSTR_LEN,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         fmt,
    input  logic [10:0]                  opcode,
    input  logic [4:0]                   rm_num,
    input  logic [5:0]                   shamt,
    input  logic [8:0]                   address,
    input  logic [4:0]                   rn_num,
    input  logic [4:0]                   rd_num,
    input  logic                         clear,
    output logic                         imem_we,
    input  logic                         imem_ready,
    output logic [ADDR_W-1:0]            imem_addr,
    output logic [INSTR_LEN-1:0]         imem_wdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        FMT_R = 1'b0,
        FMT_D = 1'b1
    } fmt_e;

    if ((64'd1 << ADDR_W) < 64'(4 * DEPTH)) begin : g_addr_check
        $error("instr_encoder: ADDR_W too narrow for DEPTH words");
    end

    logic [ADDR_W-1:0]    wr_ptr;
    logic [INSTR_LEN-1:0] enc_word;
    logic                 accept;

    always_comb begin
        enc_word = '0;
        case (fmt_e'(fmt))
            FMT_R:   enc_word = INSTR_LEN'({opcode, rm_num, shamt, rn_num, rd_num});
            FMT_D:   enc_word = INSTR_LEN'({opcode, address, 2'b00, rn_num, rd_num});
            default: enc_word = '0;
        endcase
    end

    assign full     = (count == CNT_W'(DEPTH));
    assign in_ready = !full && !clear && (!imem_we || imem_ready);
    assign accept   = in_valid && in_ready;

    // clear outranks everything and drops any word still waiting on the memory
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            count      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else if (clear) begin
            wr_ptr  <= '0;
            count   <= '0;
            imem_we <= 1'b0;
        end else if (accept) begin
            imem_wdata <= enc_word;
            imem_addr  <= wr_ptr;
            imem_we    <= 1'b1;
            wr_ptr     <= wr_ptr + ADDR_W'(4);
            count      <= count + CNT_W'(1);
        end else if (imem_ready) begin
            imem_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder; a DEPTH=4 copy shares all inputs
// so the full/clear behaviour can be exercised alongside the default-depth instance.
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        fmt;
    logic [10:0] opcode;
    logic [4:0]  rm_num;
    logic [5:0]  shamt;
    logic [8:0]  address;
    logic [4:0]  rn_num;
    logic [4:0]  rd_num;
    logic        clear;
    logic        imem_ready;

    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [6:0]  count;
    logic        full;

    logic        d4_in_ready;
    logic        d4_imem_we;
    logic [7:0]  d4_imem_addr;
    logic [31:0] d4_imem_wdata;
    logic [2:0]  d4_count;
    logic        d4_full;

    int checks = 0;
    int errors = 0;

    instr_encoder #(.INSTR_LEN(32), .DEPTH(64), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rm_num(rm_num), .shamt(shamt),
        .address(address), .rn_num(rn_num), .rd_num(rd_num), .clear(clear),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .count(count), .full(full)
    );

    instr_encoder #(.INSTR_LEN(32), .DEPTH(4), .ADDR_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d4_in_ready),
        .fmt(fmt), .opcode(opcode), .rm_num(rm_num), .shamt(shamt),
        .address(address), .rn_num(rn_num), .rd_num(rd_num), .clear(clear),
        .imem_we(d4_imem_we), .imem_ready(imem_ready), .imem_addr(d4_imem_addr),
        .imem_wdata(d4_imem_wdata), .count(d4_count), .full(d4_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic f, input logic [10:0] op, input logic [4:0] rm,
                         input logic [5:0] sh, input logic [8:0] ad,
                         input logic [4:0] rn, input logic [4:0] rd);
        fmt = f; opcode = op; rm_num = rm; shamt = sh; address = ad; rn_num = rn; rd_num = rd;
    endtask

    task automatic do_clear();
        in_valid = 1'b0;
        clear    = 1'b1;
        @(posedge clk); #1;
        clear    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; imem_ready = 1'b0;
        drive(1'b0, '0, '0, '0, '0, '0, '0);
        #3;
        checks++;
        if ({imem_we, imem_addr, imem_wdata, count, full} !== 49'd0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b addr=%0d data=%h count=%0d full=%b, want all 0",
                     imem_we, imem_addr, imem_wdata, count, full);
        end
        #9 rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_r_format();
        imem_ready = 1'b1;
        drive(1'b0, 11'b10001011000, 5'd2, 6'd0, 9'h1AB, 5'd1, 5'd3);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 32'h8B020023) begin
            errors++;
            $display("FAIL r_format_word: got we=%b addr=%0d data=%h want we=1 addr=0 data=8b020023",
                     imem_we, imem_addr, imem_wdata);
        end
        @(posedge clk); #1;
        checks++;
        if (imem_we !== 1'b0 || count !== 7'd1) begin
            errors++;
            $display("FAIL r_format_one_cycle: got we=%b count=%0d want we=0 count=1", imem_we, count);
        end
    endtask

    task automatic test_d_format();
        drive(1'b1, 11'b11111000010, 5'h1F, 6'h3F, 9'd8, 5'd10, 5'd9);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'd4 || imem_wdata !== 32'hF8408149) begin
            errors++;
            $display("FAIL d_format_word: got we=%b addr=%0d data=%h want we=1 addr=4 data=f8408149",
                     imem_we, imem_addr, imem_wdata);
        end
        @(posedge clk); #1;
        checks++;
        if (imem_we !== 1'b0 || count !== 7'd2) begin
            errors++;
            $display("FAIL d_format_drain: got we=%b count=%0d want we=0 count=2", imem_we, count);
        end
    endtask

    task automatic test_stream();
        logic        t_fmt[5];
        logic [10:0] t_op[5];
        logic [4:0]  t_rm[5];
        logic [5:0]  t_sh[5];
        logic [8:0]  t_ad[5];
        logic [4:0]  t_rn[5];
        logic [4:0]  t_rd[5];
        logic [31:0] t_exp[5];
        logic [31:0] w;
        t_fmt = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        t_op  = '{11'b10001011000, 11'b11001011000, 11'b11010011011, 11'b11111000000, 11'b11111000010};
        t_rm  = '{5'd2, 5'd7, 5'd0, 5'h15, 5'h1F};
        t_sh  = '{6'd0, 6'd0, 6'd4, 6'h2A, 6'h3F};
        t_ad  = '{9'h1FF, 9'h155, 9'h0F0, 9'd16, 9'd8};
        t_rn  = '{5'd1, 5'd6, 5'd2, 5'd4, 5'd10};
        t_rd  = '{5'd3, 5'd5, 5'd1, 5'd2, 5'd9};
        t_exp = '{32'h8B020023, 32'hCB0700C5, 32'hD3601041, 32'hF8010082, 32'hF8408149};
        do_clear();
        imem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(t_fmt[i], t_op[i], t_rm[i], t_sh[i], t_ad[i], t_rn[i], t_rd[i]);
            in_valid = 1'b1;
            @(posedge clk); #1;
            w = imem_wdata;
            checks++;
            if (imem_we !== 1'b1 || imem_addr !== 8'(4 * i) || w !== t_exp[i]) begin
                errors++;
                $display("FAIL stream_word%0d: got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                         i, imem_we, imem_addr, w, 4 * i, t_exp[i]);
            end
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready%0d: got %b want 1", i, in_ready);
            end
            checks++;
            if (w[31:21] !== t_op[i] || w[9:5] !== t_rn[i] || w[4:0] !== t_rd[i] ||
                (!t_fmt[i] && (w[20:16] !== t_rm[i] || w[15:10] !== t_sh[i])) ||
                (t_fmt[i] && (w[20:12] !== t_ad[i] || w[11:10] !== 2'b00))) begin
                errors++;
                $display("FAIL stream_decode%0d: word %h does not decode back to its fields", i, w);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (imem_we !== 1'b0 || count !== 7'd5) begin
            errors++;
            $display("FAIL stream_count: got we=%b count=%0d want we=0 count=5", imem_we, count);
        end
    endtask

    task automatic test_backpressure();
        do_clear();
        imem_ready = 1'b0;
        drive(1'b0, 11'b11001011000, 5'd7, 6'd0, 9'd0, 5'd6, 5'd5);
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive(1'b0, 11'b11010011011, 5'd0, 6'd4, 9'd0, 5'd2, 5'd1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 32'hCB0700C5 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold%0d: got we=%b addr=%0d data=%h rdy=%b want we=1 addr=0 data=cb0700c5 rdy=0",
                         k, imem_we, imem_addr, imem_wdata, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid   = 1'b0;
        imem_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (imem_we !== 1'b0 || count !== 7'd1) begin
            errors++;
            $display("FAIL backpressure_drain: got we=%b count=%0d want we=0 count=1", imem_we, count);
        end
    endtask

    task automatic test_full();
        int exp_cnt;
        do_clear();
        imem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 11'b10001011000, 5'd2, 6'd0, 9'd0, 5'd1, 5'(i));
            in_valid = 1'b1;
            @(posedge clk); #1;
            exp_cnt = (i < 4) ? i + 1 : 4;
            checks++;
            if (d4_count !== 3'(exp_cnt) || d4_full !== (i >= 3)) begin
                errors++;
                $display("FAIL full_count%0d: got count=%0d full=%b want count=%0d full=%b",
                         i, d4_count, d4_full, exp_cnt, (i >= 3));
            end
        end
        in_valid = 1'b0;
        checks++;
        if (d4_imem_addr !== 8'd12 || d4_imem_wdata !== 32'h8B020023 || d4_imem_we !== 1'b0 || d4_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_last: got addr=%0d data=%h we=%b rdy=%b want addr=12 data=8b020023 we=0 rdy=0",
                     d4_imem_addr, d4_imem_wdata, d4_imem_we, d4_in_ready);
        end
        drive(1'b0, 11'b10001011000, 5'd2, 6'd0, 9'd0, 5'd1, 5'd7);
        in_valid = 1'b1;
        clear    = 1'b1;
        #1;
        checks++;
        if (d4_in_ready !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready: got rdy4=%b rdy=%b want 0 0", d4_in_ready, in_ready);
        end
        @(posedge clk); #1;
        clear = 1'b0;
        checks++;
        if (d4_count !== 3'd0 || d4_full !== 1'b0 || d4_imem_we !== 1'b0 || count !== 7'd0 || imem_we !== 1'b0) begin
            errors++;
            $display("FAIL clear_priority: got cnt4=%0d full4=%b we4=%b cnt=%0d we=%b want all 0",
                     d4_count, d4_full, d4_imem_we, count, imem_we);
        end
        imem_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (d4_imem_addr !== 8'd0 || d4_imem_we !== 1'b1 || d4_imem_wdata !== 32'h8B020027 || d4_count !== 3'd1) begin
            errors++;
            $display("FAIL clear_restart: got addr=%0d we=%b data=%h count=%0d want addr=0 we=1 data=8b020027 count=1",
                     d4_imem_addr, d4_imem_we, d4_imem_wdata, d4_count);
        end
        do_clear();
        checks++;
        if (d4_imem_we !== 1'b0 || d4_count !== 3'd0) begin
            errors++;
            $display("FAIL clear_drop: got we=%b count=%0d want we=0 count=0", d4_imem_we, d4_count);
        end
    endtask

    task automatic test_reset_mid();
        imem_ready = 1'b0;
        drive(1'b1, 11'b11111000010, 5'd0, 6'd0, 9'd8, 5'd10, 5'd9);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_pending: got we=%b addr=%0d want we=1 addr=0", imem_we, imem_addr);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_we, imem_addr, imem_wdata, count, full} !== 49'd0 ||
            {d4_imem_we, d4_imem_addr, d4_imem_wdata, d4_count, d4_full} !== 45'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got we=%b addr=%0d data=%h count=%0d full=%b want all 0",
                     imem_we, imem_addr, imem_wdata, count, full);
        end
        #2 rst_n = 1'b1;
        imem_ready = 1'b1;
        drive(1'b0, 11'b11001011000, 5'd7, 6'd0, 9'd0, 5'd6, 5'd5);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 32'hCB0700C5 || count !== 7'd1) begin
            errors++;
            $display("FAIL reset_mid_restart: got we=%b addr=%0d data=%h count=%0d want we=1 addr=0 data=cb0700c5 count=1",
                     imem_we, imem_addr, imem_wdata, count);
        end
    endtask

    initial begin
        test_reset();
        test_r_format();
        test_d_format();
        test_stream();
        test_backpressure();
        test_full();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
